// File: rtl/duft_ap_master.sv
// duft_ap_master
// Bridges a valid/ready request/response host port onto an ap_ctrl_hs style
// slave. Only one transaction is in flight at a time. The block waits for the
// slave to report idle, pulses ap_start until ap_done, captures read data and
// then presents a response until the host takes it.
//
// Optional feature: define DUFT_MASTER_TIMEOUT_EN to enable a watchdog that
// aborts a transaction after TIMEOUT_CYCLES cycles in either wait state. An
// aborted transaction returns rsp_err=1 and rsp_rdata=0. When the macro is not
// defined, the waits are unbounded and rsp_err is tied low.
//
// Ports
//   clk, ap_rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready             host request handshake
//   req_addr/req_wdata/req_rd_wr    request address, write data, 1=read 0=write
//   rsp_valid/rsp_ready             host response handshake
//   rsp_rdata/rsp_err               read data (0 for writes/aborts), abort flag
//   addr/wr_data/rd_wr              request presented to the slave
//   ap_start                        slave start
//   ap_idle/ap_ready/ap_done        slave status (ap_ready is not used)
//   ap_return                       slave read data
module duft_ap_master #(
   parameter int TIMEOUT_CYCLES = 200
) (
   input  logic        clk,
   input  logic        ap_rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_rd_wr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] addr,
   output logic [31:0] wr_data,
   output logic        rd_wr,
   output logic        ap_start,
   input  logic        ap_idle,
   input  logic        ap_ready,
   input  logic        ap_done,
   input  logic [31:0] ap_return
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_IDLE,
      START,
      RESP
   } state_t;

   state_t state;
   logic   wait_expired;

   // The handshake outputs are pure state decodes, so they never depend
   // combinationally on any input.
   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

`ifdef DUFT_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             rsp_err_q;
   logic             unused_inputs;

   assign wait_expired  = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign rsp_err       = rsp_err_q;
   assign unused_inputs = ap_ready;

   // Watchdog: the counter restarts whenever a wait state is entered and
   // counts every cycle spent waiting. The count reaching its limit in the
   // same cycle the slave makes progress is not an abort; progress wins.
   // The error flag is cleared when the next request is accepted.
   always_ff @(posedge clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         wait_cnt  <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         if (((state == WAIT_IDLE) && !ap_idle && !wait_expired) ||
             ((state == START) && !ap_done && !wait_expired)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end else begin
            wait_cnt <= '0;
         end
         if (((state == WAIT_IDLE) && !ap_idle && wait_expired) ||
             ((state == START) && !ap_done && wait_expired)) begin
            rsp_err_q <= 1'b1;
         end else if ((state == IDLE) && req_valid) begin
            rsp_err_q <= 1'b0;
         end
      end
   end
`else
   logic unused_inputs;

   assign wait_expired  = 1'b0;
   assign rsp_err       = 1'b0;
   assign unused_inputs = ap_ready ^ (TIMEOUT_CYCLES > 0);
`endif

   // Main transaction FSM. All slave-facing outputs and the response data are
   // registered here. Outside WAIT_IDLE/START the address is parked at all
   // ones and the direction at read; the write data register keeps its last
   // value. A stale ap_done while waiting for idle is deliberately ignored.
   always_ff @(posedge clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state     <= IDLE;
         ap_start  <= 1'b0;
         addr      <= 32'hFFFF_FFFF;
         wr_data   <= 32'h0;
         rd_wr     <= 1'b1;
         rsp_rdata <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr    <= req_addr;
                  wr_data <= req_wdata;
                  rd_wr   <= req_rd_wr;
                  state   <= WAIT_IDLE;
               end
            end
            WAIT_IDLE: begin
               if (ap_idle) begin
                  ap_start <= 1'b1;
                  state    <= START;
               end else if (wait_expired) begin
                  addr      <= 32'hFFFF_FFFF;
                  rd_wr     <= 1'b1;
                  rsp_rdata <= 32'h0;
                  state     <= RESP;
               end
            end
            START: begin
               if (ap_done) begin
                  ap_start  <= 1'b0;
                  rsp_rdata <= rd_wr ? ap_return : 32'h0;
                  addr      <= 32'hFFFF_FFFF;
                  rd_wr     <= 1'b1;
                  state     <= RESP;
               end else if (wait_expired) begin
                  ap_start  <= 1'b0;
                  rsp_rdata <= 32'h0;
                  addr      <= 32'hFFFF_FFFF;
                  rd_wr     <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
